// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - registered ALU with iterative multiply/divide into HI/LO
//
// Ports:
//   CLK, RST         clock; synchronous active-low reset
//   Start            operation request, accepted only while idle
//   ALUControl       operation select, latched with Start
//   SrcA, SrcB       operands, latched with Start
//   Busy             high while an accepted operation is in flight
//   Done             one-cycle pulse when ALUResult/Hi/Lo/Zero are valid
//   ALUResult, Zero  registered result and its zero flag
//   Hi, Lo           multiply product halves / divide remainder and quotient
//   DivByZero        set by a divide with a zero divisor
module alu_muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              Zero,
  output logic [WIDTH-1:0]  Hi,
  output logic [WIDTH-1:0]  Lo,
  output logic              DivByZero
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t r_state, w_next;

  logic [SH_W-1:0]  r_cnt;
  logic             r_is_div;
  logic             r_neg;     // quotient/product negated at the end
  logic             r_negr;    // remainder takes the dividend's sign
  logic [WIDTH-1:0] r_m;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_q;       // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] r_acc;     // product upper half / partial remainder

  logic              w_is_md, w_is_div, w_signed, w_last;
  logic [SH_W-1:0]   w_shamt;
  logic [WIDTH-1:0]  w_alu, w_a_mag, w_b_mag;
  logic [WIDTH:0]    w_madd, w_dtrial;
  logic              w_dok;
  logic [WIDTH-1:0]  w_nacc, w_nq, w_quo, w_rem, w_fin_hi, w_fin_lo;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  // Opcodes 10xx are multiply/divide; bit 1 selects divide, bit 0 selects signed.
  assign w_is_md  = (ALUControl[3:2] == 2'b10);
  assign w_is_div = w_is_md & ALUControl[1];
  assign w_signed = w_is_md & ALUControl[0];
  assign w_shamt  = SrcB[SH_W-1:0];
  assign w_a_mag  = (w_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign w_b_mag  = (w_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  assign w_last   = (r_cnt == SH_W'(WIDTH - 1));

  always_comb begin
    w_alu = '0;
    case (ALUControl)
      4'b0000: w_alu = SrcA & SrcB;
      4'b0001: w_alu = SrcA | SrcB;
      4'b0010: w_alu = SrcA + SrcB;
      4'b0011: w_alu = SrcA ^ SrcB;
      4'b0100: w_alu = SrcA - SrcB;
      4'b0101: w_alu = ~(SrcA | SrcB);
      4'b0110: w_alu = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      4'b0111: w_alu = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1100: w_alu = SrcA << w_shamt;
      4'b1101: w_alu = SrcA >> w_shamt;
      4'b1110: w_alu = $signed(SrcA) >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  // Shift-add step: add multiplicand when the multiplier LSB is set, then
  // shift {carry, acc, q} right so the product grows into r_q from the top.
  assign w_madd = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_m : '0)};

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the subtraction only when it does not go negative.
  assign w_dtrial = {r_acc, r_q[WIDTH-1]} - {1'b0, r_m};
  assign w_dok    = ~w_dtrial[WIDTH];

  always_comb begin
    w_nacc = '0;
    w_nq   = '0;
    if (r_is_div) begin
      w_nacc = w_dok ? w_dtrial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
      w_nq   = {r_q[WIDTH-2:0], w_dok};
    end else begin
      w_nacc = w_madd[WIDTH:1];
      w_nq   = {w_madd[0], r_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied on the final iteration so results are registered
  // by the time Done is raised.
  assign w_prod   = {w_nacc, w_nq};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo    = r_neg ? -w_nq : w_nq;
  assign w_rem    = r_negr ? -w_nacc : w_nacc;
  assign w_fin_hi = r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_fin_lo = r_is_div ? w_quo : w_prod_s[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_is_md && !(w_is_div && (SrcB == '0))) w_next = S_RUN;
          else                                        w_next = S_FIN;
        end
      end
      S_RUN: begin
        Busy = 1'b1;
        if (w_last) w_next = S_FIN;
      end
      S_FIN: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_negr    <= 1'b0;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt     <= '0;
            r_is_div  <= w_is_div;
            r_neg     <= w_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_negr    <= w_signed & SrcA[WIDTH-1];
            r_m       <= w_b_mag;
            r_q       <= w_a_mag;
            r_acc     <= '0;
            DivByZero <= 1'b0;
            if (w_is_div && (SrcB == '0)) begin
              ALUResult <= '1;
              Zero      <= 1'b0;
              Lo        <= '1;
              Hi        <= SrcA;
              DivByZero <= 1'b1;
            end else if (!w_is_md) begin
              ALUResult <= w_alu;
              Zero      <= (w_alu == '0);
            end
          end
        end
        S_RUN: begin
          r_acc <= w_nacc;
          r_q   <= w_nq;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            Hi        <= w_fin_hi;
            Lo        <= w_fin_lo;
            ALUResult <= w_fin_lo;
            Zero      <= (w_fin_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - scoreboard bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  ALUControl = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy, Done, Zero, DivByZero;
  logic [31:0] ALUResult, Hi, Lo;

  alu_muldiv_seq #(.WIDTH(32), .CTRL_W(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .ALUResult(ALUResult), .Zero(Zero), .Hi(Hi), .Lo(Lo),
    .DivByZero(DivByZero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [31:0] res, hi, lo;
    logic        dbz, zr;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: every Done pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RST && Done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, ".result"}, ALUResult, e.res);
        chk({e.nm, ".hi"}, Hi, e.hi);
        chk({e.nm, ".lo"}, Lo, e.lo);
        chk({e.nm, ".dbz"}, {31'd0, DivByZero}, {31'd0, e.dbz});
        chk({e.nm, ".zero"}, {31'd0, Zero}, {31'd0, e.zr});
        chk({e.nm, ".latency"}, cyc - e.start, e.lat);
      end
    end
  end

  task automatic issue(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] res, logic [31:0] hi, logic [31:0] lo,
                       logic dbz, logic zr, int lat, bit poke);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    @(negedge CLK);
    ALUControl = op; SrcA = a; SrcB = b; Start = 1'b1;
    e.nm = nm; e.res = res; e.hi = hi; e.lo = lo; e.dbz = dbz; e.zr = zr;
    e.lat = lat; e.start = cyc;
    q.push_back(e);
    @(negedge CLK);
    Start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (Busy) busy_cnt++;
      if (Done) seen = 1'b1;
      else begin
        // Start pulses with different operands while busy must be ignored.
        if (poke && i >= 3 && i < 7) begin
          Start = 1'b1; ALUControl = 4'b0010; SrcA = 32'h1234_5678; SrcB = 32'h1;
        end else begin
          Start = 1'b0; ALUControl = 4'b0101; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0;
        end
        @(negedge CLK);
      end
    end
    Start = 1'b0;
    chk({nm, ".done_seen"}, {31'd0, seen}, 32'd1);
    chk({nm, ".busy_cycles"}, busy_cnt, lat);
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    chk("rst.done", {31'd0, Done}, 32'd0);
    chk("rst.result", ALUResult, 32'd0);
    chk("rst.hi", Hi, 32'd0);
    chk("rst.lo", Lo, 32'd0);
    chk("rst.dbz", {31'd0, DivByZero}, 32'd0);
    chk("rst.zero", {31'd0, Zero}, 32'd0);
    RST = 1'b1;

    issue("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1, 0);
    issue("sub_zero", 4'b0100, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
    issue("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0, 0, 0, 1, 0);
    issue("sltu", 4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
    issue("reserved", 4'b1111, 32'h1234_5678, 32'h9, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0);
    issue("mult", 4'b1001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 33, 1);
    issue("add_keep_hilo", 4'b0010, 32'd1, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 1, 0);
    issue("div", 4'b1011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 33, 0);
    issue("divu_by0", 4'b1010, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 1, 0, 1, 0);
    issue("add_clr_dbz", 4'b0010, 32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFF, 0, 1, 1, 0);
    issue("sra", 4'b1110, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 0);
    issue("srl", 4'b1101, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 0);
    issue("sll", 4'b1100, 32'h1, 32'd36, 32'h0000_0010, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 0);
    issue("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd7, 32'hFFFF_FFFF, 0, 0, 1, 0);
    issue("nor", 4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 32'd7, 32'hFFFF_FFFF, 0, 1, 1, 0);
    issue("multu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 33, 0);
    issue("div_minneg", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 0, 0, 33, 0);
    issue("divu", 4'b1010, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 0, 0, 33, 0);
    issue("div_negdiv", 4'b1011, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD, 0, 0, 33, 0);
    issue("mult_negneg", 4'b1001, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd20, 32'd0, 32'd20, 0, 0, 33, 0);

    // Reset in the middle of a multiply: no Done, everything cleared.
    @(negedge CLK);
    ALUControl = 4'b1000; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    chk("midrst.busy_before", {31'd0, Busy}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst.busy", {31'd0, Busy}, 32'd0);
    chk("midrst.done", {31'd0, Done}, 32'd0);
    chk("midrst.result", ALUResult, 32'd0);
    chk("midrst.hi", Hi, 32'd0);
    chk("midrst.lo", Lo, 32'd0);
    chk("midrst.dbz", {31'd0, DivByZero}, 32'd0);
    chk("midrst.zero", {31'd0, Zero}, 32'd0);
    RST = 1'b1;
    issue("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 32'd0, 32'd0, 0, 0, 1, 0);

    repeat (40) @(negedge CLK);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
